// File: rtl/adaptive_filter_pkg.sv
// Shared types and helpers for the adaptive filter and its scheduler.
// Samples are signed Q8.6, 14 bits wide.
package adaptive_filter_pkg;

    localparam int WORDLENGTH        = 14;
    localparam int FRACTIONAL_LENGTH = 6;

    typedef logic signed [WORDLENGTH-1:0] sample_t;

    typedef enum logic {
        MODE_DIFF  = 1'b0,
        MODE_INTEG = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        ST_FLUSH,
        ST_RUN,
        ST_DRAIN
    } sched_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/adaptive_filter_sched_if.sv
// Sample stream, mode-request channel and result stream of the scheduler.
// The slave side is the scheduler; the master side is the sample source/sink.
interface adaptive_filter_sched_if #(
    parameter int DATA_WIDTH = 14
);
    logic                  s_tvalid;
    logic                  s_tready;
    logic [DATA_WIDTH-1:0] s_tdata;
    logic                  mode_req_valid;
    logic                  mode_req;
    logic                  mode_req_ready;
    logic                  m_tvalid;
    logic [DATA_WIDTH-1:0] m_tdata;

    modport slave (
        input  s_tvalid, s_tdata, mode_req_valid, mode_req,
        output s_tready, mode_req_ready, m_tvalid, m_tdata
    );

    modport master (
        output s_tvalid, s_tdata, mode_req_valid, mode_req,
        input  s_tready, mode_req_ready, m_tvalid, m_tdata
    );
endinterface

// File: rtl/adaptive_filter.sv
// Integrator (ctrl=1) / differentiator (ctrl=0) with one cycle of latency.
// srst clears both the running sum and the previous-sample history.
module adaptive_filter #(
    parameter int DATA_WIDTH = 14
) (
    input  logic                         clk,
    input  logic                         srst,
    input  logic                         ctrl,
    input  logic signed [DATA_WIDTH-1:0] s_tdata,
    output logic signed [DATA_WIDTH-1:0] m_tdata
);
    logic signed [DATA_WIDTH-1:0] out_q;
    logic signed [DATA_WIDTH-1:0] prev_q;

    always_ff @(posedge clk) begin
        if (srst) begin
            out_q  <= '0;
            prev_q <= '0;
        end else begin
            prev_q <= s_tdata;
            out_q  <= ctrl ? (out_q + s_tdata) : (s_tdata - prev_q);
        end
    end

    assign m_tdata = out_q;

endmodule

// File: rtl/adaptive_filter_sched_valid_delay_line.sv
// Shift register that carries sample tags alongside the filter pipeline.
module valid_delay_line #(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic srst_n,
    input  logic din,
    output logic dout
);
    logic [DEPTH-1:0] shift_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_stage
            always_ff @(posedge clk) begin
                if (!srst_n) begin
                    shift_q[gi] <= 1'b0;
                end else if (gi == 0) begin
                    shift_q[gi] <= din;
                end else begin
                    shift_q[gi] <= shift_q[(gi == 0) ? 0 : gi-1];
                end
            end
        end
    endgenerate

    assign dout = shift_q[DEPTH-1];

endmodule

// File: rtl/adaptive_filter_sched.sv
// Sequences one adaptive_filter: tags samples in flight, drains them before a
// mode switch, then holds the filter in reset so history never crosses modes.
module adaptive_filter_sched
    import adaptive_filter_pkg::*;
#(
    parameter int   DATA_WIDTH     = 14,
    parameter int   FILTER_LATENCY = 1,
    parameter int   FLUSH_CYCLES   = 2,
    parameter logic DEFAULT_MODE   = 1'b1
) (
    input  logic                  clk,
    input  logic                  srst_n,
    adaptive_filter_sched_if.slave bus,
    output logic                  flt_srst,
    output logic                  flt_ctrl,
    output logic [DATA_WIDTH-1:0] flt_s_tdata,
    input  logic [DATA_WIDTH-1:0] flt_m_tdata,
    output logic                  cur_mode,
    output logic                  busy
);
    localparam int CNT_MAX = max_int(FLUSH_CYCLES, FILTER_LATENCY + 1);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    sched_state_t          state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  cur_mode_q, cur_mode_d;
    logic                  pending_q, pending_d;
    logic [DATA_WIDTH-1:0] flt_s_tdata_q;
    logic [DATA_WIDTH-1:0] m_tdata_q;
    logic                  tag_q;
    logic                  m_tvalid_q;
    logic                  line_out;
    logic                  run;
    logic                  s_fire;
    logic                  m_fire;

    assign run    = (state_q == ST_RUN);
    assign s_fire = bus.s_tvalid && run;
    assign m_fire = bus.mode_req_valid && run;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        cur_mode_d = cur_mode_q;
        pending_d  = pending_q;
        case (state_q)
            ST_FLUSH: begin
                if (cnt_q == CNT_W'(FLUSH_CYCLES - 1)) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RUN: begin
                // A request for the mode already applied is simply acknowledged.
                if (m_fire && (bus.mode_req != cur_mode_q)) begin
                    pending_d = bus.mode_req;
                    state_d   = ST_DRAIN;
                    cnt_d     = '0;
                end
            end
            ST_DRAIN: begin
                // New mode lands on the same edge the filter reset is raised.
                if (cnt_q == CNT_W'(FILTER_LATENCY)) begin
                    state_d    = ST_FLUSH;
                    cnt_d      = '0;
                    cur_mode_d = pending_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_FLUSH;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!srst_n) begin
            state_q       <= ST_FLUSH;
            cnt_q         <= '0;
            cur_mode_q    <= DEFAULT_MODE;
            pending_q     <= DEFAULT_MODE;
            flt_s_tdata_q <= '0;
            tag_q         <= 1'b0;
            m_tvalid_q    <= 1'b0;
            m_tdata_q     <= '0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            cur_mode_q    <= cur_mode_d;
            pending_q     <= pending_d;
            flt_s_tdata_q <= s_fire ? bus.s_tdata : '0;
            tag_q         <= s_fire;
            m_tvalid_q    <= line_out;
            m_tdata_q     <= flt_m_tdata;
        end
    end

    valid_delay_line #(
        .DEPTH (FILTER_LATENCY)
    ) u_valid_line (
        .clk    (clk),
        .srst_n (srst_n),
        .din    (tag_q),
        .dout   (line_out)
    );

    assign bus.s_tready       = run;
    assign bus.mode_req_ready = run;
    assign bus.m_tvalid       = m_tvalid_q;
    assign bus.m_tdata        = m_tdata_q;
    assign flt_srst           = (state_q == ST_FLUSH);
    assign flt_ctrl           = cur_mode_q;
    assign flt_s_tdata        = flt_s_tdata_q;
    assign cur_mode           = cur_mode_q;
    assign busy               = !run;

endmodule
